// File: rtl/car_traffic_controller.sv
// Car traffic for the frog game: advances four lanes once per frame, wraps cars at
// the screen edges and flags a frog/car overlap, then freezes traffic for a while.
module car_traffic_controller #(
  parameter int TILE_SIZE      = 32,
  parameter int H_VISIBLE_AREA = 640,
  parameter int BASE_STEP      = 2,
  parameter int FREEZE_FRAMES  = 30,
  parameter int LANE1_Y        = 64,
  parameter int LANE2_Y        = 128,
  parameter int LANE3_Y        = 192,
  parameter int LANE4_Y        = 256,
  parameter int CAR1_X0        = 0,
  parameter int CAR2_X0        = 320,
  parameter int CAR3_X0        = 160,
  parameter int CAR4_X0        = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Enable,
  input  logic [2:0] i_Level,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  output logic [9:0] o_Car_1X,
  output logic [9:0] o_Car_2X,
  output logic [9:0] o_Car_3X,
  output logic [9:0] o_Car_4X,
  output logic [9:0] o_Car_1Y,
  output logic [9:0] o_Car_2Y,
  output logic [9:0] o_Car_3Y,
  output logic [9:0] o_Car_4Y,
  output logic       o_Hit,
  output logic       o_Frozen,
  output logic [1:0] o_State
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] FREEZE = 2'd3;

  localparam int          CW     = $clog2(FREEZE_FRAMES + 1);
  localparam logic [10:0] X_MAX  = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0] TILE11 = 11'(TILE_SIZE);

  logic [1:0]    state;
  logic [9:0]    car_x [4];
  logic [9:0]    lane_y [4];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [10:0]   step;
  logic          hit_any;

  assign lane_y[0] = 10'(LANE1_Y);
  assign lane_y[1] = 10'(LANE2_Y);
  assign lane_y[2] = 10'(LANE3_Y);
  assign lane_y[3] = 10'(LANE4_Y);

  assign step    = 11'(BASE_STEP) + {8'd0, i_Level};
  assign cnt_nxt = cnt + CW'(1);

  // All arithmetic is 11 bits wide so X + step can never overflow before the wrap test.
  function automatic logic [9:0] move_x(input logic [9:0] x, input logic right,
                                        input logic [10:0] stp);
    logic [10:0] x11;
    logic [10:0] nx;
    x11 = {1'b0, x};
    if (right) begin
      nx = x11 + stp;
      move_x = (nx > X_MAX) ? 10'd0 : 10'(nx);
    end else begin
      nx = x11 - stp;
      move_x = (x11 < stp) ? 10'(X_MAX) : 10'(nx);
    end
  endfunction

  function automatic logic overlap(input logic [9:0] cx, input logic [9:0] cy,
                                   input logic [9:0] fx, input logic [9:0] fy);
    logic [10:0] cx11, cy11, fx11, fy11;
    cx11 = {1'b0, cx};
    cy11 = {1'b0, cy};
    fx11 = {1'b0, fx};
    fy11 = {1'b0, fy};
    overlap = (fx11 < cx11 + TILE11) && (cx11 < fx11 + TILE11) &&
              (fy11 < cy11 + TILE11) && (cy11 < fy11 + TILE11);
  endfunction

  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (overlap(car_x[i], lane_y[i], i_Frog_X, i_Frog_Y)) hit_any = 1'b1;
    end
  end

  // Timing contract: a tick accepted in RUN moves the cars on that edge (CHECK next),
  // and o_Hit/o_Frozen rise together one edge later; o_Hit is a single-cycle pulse.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      car_x[0] <= 10'(CAR1_X0);
      car_x[1] <= 10'(CAR2_X0);
      car_x[2] <= 10'(CAR3_X0);
      car_x[3] <= 10'(CAR4_X0);
      o_Hit    <= 1'b0;
      o_Frozen <= 1'b0;
      cnt      <= '0;
    end else begin
      o_Hit <= 1'b0;
      if (!i_Enable) begin
        state    <= IDLE;
        o_Frozen <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: state <= RUN;
          RUN: begin
            if (i_Frame_Tick) begin
              for (int i = 0; i < 4; i++) begin
                car_x[i] <= move_x(car_x[i], (i % 2) == 0, step);
              end
              state <= CHECK;
            end
          end
          CHECK: begin
            if (hit_any) begin
              o_Hit    <= 1'b1;
              o_Frozen <= 1'b1;
              cnt      <= '0;
              state    <= FREEZE;
            end else begin
              state <= RUN;
            end
          end
          FREEZE: begin
            if (i_Frame_Tick) begin
              if (cnt_nxt == CW'(FREEZE_FRAMES)) begin
                state    <= RUN;
                o_Frozen <= 1'b0;
                cnt      <= '0;
              end else begin
                cnt <= cnt_nxt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_Car_1X = car_x[0];
  assign o_Car_2X = car_x[1];
  assign o_Car_3X = car_x[2];
  assign o_Car_4X = car_x[3];
  assign o_Car_1Y = lane_y[0];
  assign o_Car_2Y = lane_y[1];
  assign o_Car_3Y = lane_y[2];
  assign o_Car_4Y = lane_y[3];
  assign o_State  = state;

endmodule

// File: tb/tb_car_traffic_controller.sv
// Randomised bench for car_traffic_controller: a frame-level reference model predicts
// car positions, hit and freeze status; a monitor compares them two cycles after each tick.
module tb_car_traffic_controller;

  localparam int W    = 82;
  localparam int FF   = 30;
  localparam int XMAX = 608;
  localparam int TILE = 32;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       tick = 1'b0;
  logic       probe = 1'b0;
  logic       en = 1'b0;
  logic [2:0] level = 3'd0;
  logic [9:0] frog_x = 10'd1000;
  logic [9:0] frog_y = 10'd1000;
  logic [9:0] c1x, c2x, c3x, c4x, c1y, c2y, c3y, c4y;
  logic       hit, frozen;
  logic [1:0] dbg_state;

  car_traffic_controller dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Frame_Tick(tick), .i_Enable(en),
    .i_Level(level), .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
    .o_Car_1X(c1x), .o_Car_2X(c2x), .o_Car_3X(c3x), .o_Car_4X(c4x),
    .o_Car_1Y(c1y), .o_Car_2Y(c2y), .o_Car_3Y(c3y), .o_Car_4Y(c4y),
    .o_Hit(hit), .o_Frozen(frozen), .o_State(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic [2:0] obs_pipe = 3'b000;

  // reference model: frame-level view of the traffic
  int car_m [4];
  int lane_m [4] = '{64, 128, 192, 256};
  int frz_left = 0;
  bit en_m = 1'b0;

  always @(posedge clk) obs_pipe <= {obs_pipe[1:0], tick | probe};

  function automatic int next_x(input int idx, input int x, input int lvl);
    int stp;
    int n;
    stp = 2 + lvl;
    if (idx % 2 == 0) begin
      n = x + stp;
      if (n > XMAX) n = 0;
    end else begin
      if (x < stp) n = XMAX;
      else n = x - stp;
    end
    return n;
  endfunction

  function automatic bit touches(input int cx, input int cy, input int fx, input int fy);
    return (fx < cx + TILE) && (cx < fx + TILE) && (fy < cy + TILE) && (cy < fy + TILE);
  endfunction

  function automatic logic [W-1:0] pack(input bit h, input bit f);
    return {10'(car_m[0]), 10'(car_m[1]), 10'(car_m[2]), 10'(car_m[3]),
            10'(lane_m[0]), 10'(lane_m[1]), 10'(lane_m[2]), 10'(lane_m[3]), h, f};
  endfunction

  function automatic int clamp10(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // driver tasks
  task automatic do_tick();
    bit h;
    h = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    if (en_m) begin
      if (frz_left > 0) begin
        frz_left--;
      end else begin
        for (int i = 0; i < 4; i++) car_m[i] = next_x(i, car_m[i], int'(level));
        for (int i = 0; i < 4; i++)
          if (touches(car_m[i], lane_m[i], int'(frog_x), int'(frog_y))) h = 1'b1;
        if (h) frz_left = FF;
      end
    end
    exp_q.push_back(pack(h, frz_left > 0));
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_en(input bit e);
    @(negedge clk);
    en = e;
    en_m = e;
    if (!e) frz_left = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    car_m = '{0, 320, 160, 480};
    frz_left = 0;
    @(negedge clk);
    rst_l = 1'b1;
    probe = 1'b1;
    exp_q.push_back(pack(1'b0, 1'b0));
    @(negedge clk);
    probe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic aim_frog(input int c, input int dx, input int dy);
    frog_x = 10'(clamp10(next_x(c, car_m[c], int'(level)) + dx));
    frog_y = 10'(clamp10(lane_m[c] + dy));
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {c1x, c2x, c3x, c4x, c1y, c2y, c3y, c4y, hit, frozen};
    if (obs_pipe[1]) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got=%h required=<none queued>", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL resp: got x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d hit=%b frz=%b required x=%0d,%0d,%0d,%0d y=%0d,%0d,%0d,%0d hit=%b frz=%b",
                   got[81:72], got[71:62], got[61:52], got[51:42], got[41:32], got[31:22],
                   got[21:12], got[11:2], got[1], got[0], e[81:72], e[71:62], e[61:52],
                   e[51:42], e[41:32], e[31:22], e[21:12], e[11:2], e[1], e[0]);
        end
      end
    end else if (obs_pipe[2]) begin
      total++;
      if (hit !== 1'b0) begin
        bad++;
        $display("FAIL hit_pulse_width: got=%b required=0", hit);
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    do_reset();

    // traffic held while disabled
    for (int i = 0; i < 10; i++) do_tick();

    set_en(1'b1);
    level = 3'd3;
    do_tick();

    // hit one pixel inside the car, freeze a few frames, then reset mid-freeze
    level = 3'd0;
    aim_frog(0, 31, 0);
    do_tick();
    frog_x = 10'd1000;
    frog_y = 10'd1000;
    for (int i = 0; i < 5; i++) do_tick();
    do_reset();

    // edge-touching is not a hit
    aim_frog(0, 32, 0);
    do_tick();
    aim_frog(0, -32, 0);
    do_tick();

    // hit, then disable mid-freeze
    aim_frog(1, 0, 31);
    do_tick();
    frog_x = 10'd1000;
    for (int i = 0; i < 3; i++) do_tick();
    set_en(1'b0);
    do_tick();
    set_en(1'b1);
    do_tick();

    // hit and sit out the whole freeze
    level = 3'd7;
    aim_frog(2, -31, -31);
    do_tick();
    frog_x = 10'd1000;
    frog_y = 10'd1000;
    for (int i = 0; i < FF + 3; i++) do_tick();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 8) begin
        set_en(!en_m);
      end else begin
        level = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) begin
          aim_frog($urandom_range(0, 3), $urandom_range(0, 66) - 33, $urandom_range(0, 66) - 33);
        end else begin
          frog_x = 10'($urandom_range(0, 1023));
          frog_y = 10'($urandom_range(0, 1023));
        end
        do_tick();
      end
    end

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
